// File: rtl/frac_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frac_div_ctrl
// Purpose  : Multi-modulus divider controller for a fractional-N PLL. It adds
//            the signed DSM output to the integer ratio once per divided
//            period, saturates the sum to a legal ratio R, and counts R clock
//            cycles while producing the divided clock and a DSM step strobe.
// Revision : 1.0 - initial release
// ============================================================================
module frac_div_ctrl #(
  parameter int N_WIDTH   = 8,
  parameter int DSM_WIDTH = 5,
  parameter int MIN_DIV   = 4   // must be >= 2 so both clock phases exist
) (
  input  logic                 Clk,
  input  logic                 reset,     // asynchronous, active low
  input  logic                 En,
  input  logic [N_WIDTH-1:0]   N_Int,
  input  logic [DSM_WIDTH-1:0] Dsm_Data,
  output logic                 Div_Out,
  output logic                 Dsm_Step,
  output logic [N_WIDTH-1:0]   Div_Ratio,
  output logic                 Clamp
);

  // Two extra bits: one for the carry of the add, one for the sign.
  localparam int SUM_W = N_WIDTH + 2;

  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(MIN_DIV);
  localparam logic signed [SUM_W-1:0] MAX_S = {2'b00, {N_WIDTH{1'b1}}};
  localparam logic [N_WIDTH-1:0]      MIN_R = N_WIDTH'(MIN_DIV);
  localparam logic [N_WIDTH-1:0]      MAX_R = {N_WIDTH{1'b1}};
  localparam logic [N_WIDTH-1:0]      ONE_R = N_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [N_WIDTH-1:0]   cnt_q, cnt_d;
  logic [N_WIDTH-1:0]   ratio_q, ratio_d;
  logic                 clamp_q, clamp_d;
  logic                 div_q, div_d;
  logic                 step_q, step_d;

  logic signed [SUM_W-1:0] n_ext_w;
  logic signed [SUM_W-1:0] dsm_ext_w;
  logic signed [SUM_W-1:0] sum_w;
  logic [N_WIDTH-1:0]      ratio_w;
  logic                    sat_w;
  logic                    load_w;

  // Integer ratio is unsigned (zero-extend); DSM word is two's complement.
  assign n_ext_w   = {2'b00, N_Int};
  assign dsm_ext_w = {{(SUM_W-DSM_WIDTH){Dsm_Data[DSM_WIDTH-1]}}, Dsm_Data};
  assign sum_w     = n_ext_w + dsm_ext_w;

  // A new period starts whenever the counter is exhausted (or we are idle)
  // and the block is enabled; this is the only time inputs are sampled.
  assign load_w = En && ((state_q == IDLE) || (cnt_q == '0));

  // Saturate the raw sum into the legal ratio window [MIN_DIV, 2^N-1].
  always_comb begin
    ratio_w = sum_w[N_WIDTH-1:0];
    sat_w   = 1'b0;
    if (sum_w < MIN_S) begin
      ratio_w = MIN_R;
      sat_w   = 1'b1;
    end else if (sum_w > MAX_S) begin
      ratio_w = MAX_R;
      sat_w   = 1'b1;
    end
  end

  // Next-state and registered-output logic for the period counter FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    clamp_d = clamp_q;
    step_d  = 1'b0;
    div_d   = 1'b0;

    if (load_w) begin
      state_d = RUN;
      cnt_d   = ratio_w - ONE_R;
      ratio_d = ratio_w;
      clamp_d = sat_w;
      step_d  = 1'b1;
    end else if ((state_q == RUN) && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE_R;
    end else begin
      // Period finished with En low, or idling: park, keep last ratio.
      state_d = IDLE;
      cnt_d   = '0;
      clamp_d = 1'b0;
    end

    // High while the count is in the upper half; odd R gives the extra
    // cycle to the high phase because the count runs R-1 down to 0.
    div_d = (state_d == RUN) && (cnt_d >= (ratio_d >> 1));
  end

  // State, counter and output registers with asynchronous abort.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ratio_q <= '0;
      clamp_q <= 1'b0;
      div_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      clamp_q <= clamp_d;
      div_q   <= div_d;
      step_q  <= step_d;
    end
  end

  assign Div_Out   = div_q;
  assign Dsm_Step  = step_q;
  assign Div_Ratio = ratio_q;
  assign Clamp     = clamp_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frac_div_ctrl
// Purpose  : Directed self-checking bench for frac_div_ctrl. Expected period
//            descriptors are queued when the inputs for a period are driven
//            and popped when that period is observed on the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frac_div_ctrl;

  logic       Clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       En       = 1'b0;
  logic [7:0] N_Int    = 8'd10;
  logic [4:0] Dsm_Data = 5'd0;
  logic       Div_Out;
  logic       Dsm_Step;
  logic [7:0] Div_Ratio;
  logic       Clamp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int r;
    int c;
  } exp_t;

  exp_t sb[$];

  frac_div_ctrl #(
    .N_WIDTH  (8),
    .DSM_WIDTH(5),
    .MIN_DIV  (4)
  ) dut (
    .Clk      (Clk),
    .reset    (reset),
    .En       (En),
    .N_Int    (N_Int),
    .Dsm_Data (Dsm_Data),
    .Div_Out  (Div_Out),
    .Dsm_Step (Dsm_Step),
    .Div_Ratio(Div_Ratio),
    .Clamp    (Clamp)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference ratio: clamp N+D into [4, 255].
  function automatic exp_t model(input int n, input int d);
    exp_t e;
    int   s;
    s = n + d;
    if (s < 4)        e.r = 4;
    else if (s > 255) e.r = 255;
    else              e.r = s;
    e.c = (e.r != s) ? 1 : 0;
    return e;
  endfunction

  task automatic push(input int n, input int d);
    N_Int    = n[7:0];
    Dsm_Data = d[4:0];
    sb.push_back(model(n, d));
  endtask

  // Advance to a negedge where Dsm_Step is high (bounded).
  task automatic wait_step(input string tag);
    int k = 0;
    while (Dsm_Step !== 1'b1 && k < 400) begin
      @(negedge Clk);
      k++;
    end
    check(tag, int'(Dsm_Step), 1);
  endtask

  // Called at the negedge of the first cycle of a period. Drives the inputs
  // for the next period, then measures the current one against the queue.
  task automatic period(input int n, input int d, input int mid_n,
                        input int mid_at, output int len);
    exp_t e;
    int   hi;
    bit   found;
    if (mid_at == 0) push(n, d);
    else begin
      N_Int    = n[7:0];
      Dsm_Data = d[4:0];
    end
    e = '{0, 0};
    if (sb.size() > 0) e = sb.pop_front();
    check("ratio", int'(Div_Ratio), e.r);
    check("clamp", int'(Clamp), e.c);
    len   = 1;
    hi    = int'(Div_Out);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge Clk);
      if (Dsm_Step === 1'b1) found = 1'b1;
      else begin
        len++;
        hi += int'(Div_Out);
        if (mid_at != 0 && len == mid_at) push(mid_n, d);
      end
    end
    check("period_len", len, e.r);
    check("high_cycles", hi, (e.r + 1) / 2);
  endtask

  initial begin
    int   len;
    int   total;
    int   hi;
    int   cyc;
    int   ones;
    exp_t e;

    // Reset held: all outputs zero.
    reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_div_out", int'(Div_Out), 0);
    check("rst_dsm_step", int'(Dsm_Step), 0);
    check("rst_div_ratio", int'(Div_Ratio), 0);
    check("rst_clamp", int'(Clamp), 0);

    // Release with En=1, N=10, D=0: first edge loads.
    sb.push_back(model(10, 0));
    En    = 1'b1;
    reset = 1'b1;
    @(negedge Clk);
    wait_step("first_step");

    period(10, 0, 0, 0, len);    // observes 10
    period(10, -3, 0, 0, len);   // observes 10, queues 7
    period(10, 4, 0, 0, len);    // observes 7, queues 14
    period(10, 0, 0, 0, len);    // observes 14, queues 10

    // Fractional average: toggle D 0/+1 on each step.
    total = 0;
    for (int i = 0; i < 20; i++) begin
      period(10, (i % 2 == 0) ? 1 : 0, 0, 0, len);
      total += len;
    end
    check("frac_total_210", total, 210);

    // Clamping cases.
    period(2, -3, 0, 0, len);    // observes 10, queues 4 clamped
    period(255, 7, 0, 0, len);   // observes 4/1, queues 255 clamped
    period(100, 7, 0, 0, len);   // observes 255/1, queues 107
    period(10, 0, 0, 0, len);    // observes 107/0, queues 10

    // Mid-period change of N_Int at cycle 3.
    period(10, 0, 20, 3, len);   // observes 10, queues 20
    period(10, 0, 0, 0, len);    // observes 20, queues 10

    // En dropped at cycle 2 of a 10-cycle period.
    e = '{0, 0};
    if (sb.size() > 0) e = sb.pop_front();
    check("en_drop_ratio", int'(Div_Ratio), e.r);
    hi  = int'(Div_Out);
    cyc = 1;
    @(negedge Clk);
    cyc++;
    hi += int'(Div_Out);
    En = 1'b0;
    ones = 0;
    while (cyc < 10) begin
      @(negedge Clk);
      cyc++;
      hi   += int'(Div_Out);
      ones += int'(Dsm_Step);
    end
    check("en_drop_high", hi, 5);
    check("en_drop_no_step_in_period", ones, 0);
    ones = 0;
    repeat (30) begin
      @(negedge Clk);
      ones += int'(Div_Out) + int'(Dsm_Step);
    end
    check("idle_quiet", ones, 0);
    check("idle_ratio_hold", int'(Div_Ratio), 10);
    check("idle_clamp", int'(Clamp), 0);

    // Asynchronous reset at cycle 5 of a running period.
    N_Int    = 8'd10;
    Dsm_Data = 5'd0;
    En       = 1'b1;
    @(negedge Clk);
    wait_step("restart_step");
    repeat (4) @(negedge Clk);
    check("pre_reset_div_out", int'(Div_Out), 1);
    #1 reset = 1'b0;
    #1;
    check("async_div_out", int'(Div_Out), 0);
    check("async_dsm_step", int'(Dsm_Step), 0);
    check("async_div_ratio", int'(Div_Ratio), 0);
    check("async_clamp", int'(Clamp), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
